// File: rtl/matmul_pkg.sv
// Shared types for the matmul sequencer: the job FSM state encoding and the default
// WAIT-timeout scale factor (timeout = TimeoutMult * N_SIZE cycles).
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFeed,
    StWait,
    StCapt,
    StDrain
  } state_e;

  localparam int unsigned TimeoutMult = 4;

endpackage

// File: rtl/operand_bank.sv
// A/B operand storage: whole rows are written by the host; a k-slice (column k of A,
// row k of B) is read combinationally while feeding the array.
module operand_bank #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned N_SIZE    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en_i,
  input  logic                             wr_sel_i,
  input  logic [$clog2(N_SIZE)-1:0]        wr_idx_i,
  input  logic [N_SIZE*DATAWIDTH-1:0]      wr_data_i,
  input  logic [$clog2(N_SIZE)-1:0]        rd_k_i,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0] col_a_o,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0] row_b_o
);

  // Indexed [row][col]; element 0 of a written row lands in column 0.
  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] a_q;
  logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr_en_i) begin
      if (wr_sel_i) begin
        b_q[wr_idx_i] <= wr_data_i;
      end else begin
        a_q[wr_idx_i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    col_a_o = '0;
    for (int unsigned i = 0; i < N_SIZE; i++) begin
      col_a_o[i] = a_q[i][rd_k_i];
    end
    row_b_o = b_q[rd_k_i];
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Job sequencer for an N x N matrix-multiply array: clears the array, feeds A/B k-slices,
// waits for and captures the result rows, then streams them out over a ready/valid port.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned N_SIZE    = 3,
  parameter int unsigned TIMEOUT   = TimeoutMult * N_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [$clog2(N_SIZE)-1:0]          wr_idx,
  input  logic [N_SIZE*DATAWIDTH-1:0]        wr_data,
  output logic                               wr_err,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic                               arr_rst_n,
  output logic                               arr_valid_in,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]   arr_a,
  output logic [N_SIZE-1:0][DATAWIDTH-1:0]   arr_b,
  input  logic                               arr_valid_out,
  input  logic [N_SIZE-1:0][2*DATAWIDTH-1:0] arr_c,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [N_SIZE*2*DATAWIDTH-1:0]      res_row,
  output logic [$clog2(N_SIZE)-1:0]          res_idx
);

  localparam int unsigned IdxW   = $clog2(N_SIZE);
  localparam int unsigned CntMax = (TIMEOUT > N_SIZE) ? TIMEOUT : N_SIZE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e                                    state_q, state_d;
  logic [CntW-1:0]                           cnt_q, cnt_d;
  logic [IdxW-1:0]                           row_q, row_d;
  logic                                      done_q, done_d;
  logic                                      err_q, err_d;
  logic                                      wr_err_q, wr_err_d;
  logic                                      arr_rst_n_q, arr_rst_n_d;
  logic [N_SIZE-1:0][N_SIZE*2*DATAWIDTH-1:0] res_q;
  logic                                      cap_en;
  logic                                      wr_accept;
  logic                                      feed;
  logic [N_SIZE-1:0][DATAWIDTH-1:0]          col_a, row_b;

  // Out-of-range row indices are rejected like writes attempted while busy.
  assign wr_accept = wr_en && (state_q == StIdle) && (32'(wr_idx) < N_SIZE);
  assign wr_err_d  = wr_en && !wr_accept;

  operand_bank #(
    .DATAWIDTH (DATAWIDTH),
    .N_SIZE    (N_SIZE)
  ) u_operand_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_accept),
    .wr_sel_i  (wr_sel),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_k_i    (cnt_q[IdxW-1:0]),
    .col_a_o   (col_a),
    .row_b_o   (row_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClr;
          err_d   = 1'b0;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      StClr: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt_q == CntW'(N_SIZE - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        // The first valid row arrives here and is captured as row 0.
        if (arr_valid_out) begin
          cap_en  = 1'b1;
          row_d   = IdxW'(1);
          state_d = StCapt;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapt: begin
        if (arr_valid_out) begin
          cap_en = 1'b1;
          if (row_q == IdxW'(N_SIZE - 1)) begin
            state_d = StDrain;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (res_ready) begin
          if (row_q == IdxW'(N_SIZE - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    arr_rst_n_d = (state_d != StClr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_err_q    <= 1'b0;
      arr_rst_n_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_err_q    <= wr_err_d;
      arr_rst_n_q <= arr_rst_n_d;
      if (cap_en) begin
        res_q[row_q] <= arr_c;
      end
    end
  end

  assign feed         = (state_q == StFeed);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign wr_err       = wr_err_q;
  assign arr_rst_n    = arr_rst_n_q;
  assign arr_valid_in = feed;
  assign arr_a        = feed ? col_a : '0;
  assign arr_b        = feed ? row_b : '0;
  assign res_valid    = (state_q == StDrain);
  assign res_idx      = row_q;
  assign res_row      = res_q[row_q];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a behavioural array stub plus a plain-arithmetic A*B model
// drive directed and randomized jobs and check every streamed row and control pulse.
module tb_matmul_sequencer;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int TO = 4 * N;
  localparam int IW = $clog2(N);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_en, wr_sel, start, arr_valid_out, res_ready;
  logic [IW-1:0]            wr_idx;
  logic [N*DW-1:0]          wr_data;
  logic                     wr_err, busy, done, err, arr_rst_n, arr_valid_in, res_valid;
  logic [N-1:0][DW-1:0]     arr_a, arr_b;
  logic [N-1:0][2*DW-1:0]   arr_c;
  logic [N*2*DW-1:0]        res_row;
  logic [IW-1:0]            res_idx;

  int unsigned ma [N][N];
  int unsigned mb [N][N];
  int total = 0, passed = 0, fails = 0;

  // Array stub configuration and state.
  int stub_lat = 0, stub_gap = 0, stub_gap_after = 0;
  bit stub_never = 1'b0;
  int emit_row = -1, delay_left = 0, beats = 0;
  logic [2*DW-1:0] acc [N][N];

  matmul_sequencer #(
    .DATAWIDTH (DW),
    .N_SIZE    (N),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_err        (wr_err),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .arr_rst_n     (arr_rst_n),
    .arr_valid_in  (arr_valid_in),
    .arr_a         (arr_a),
    .arr_b         (arr_b),
    .arr_valid_out (arr_valid_out),
    .arr_c         (arr_c),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_row       (res_row),
    .res_idx       (res_idx)
  );

  always #5 clk = ~clk;

  // Outer-product accumulator array; emits rows after stub_lat cycles once N beats are in.
  always @(negedge clk) begin
    arr_valid_out = 1'b0;
    arr_c = '0;
    if (!arr_rst_n) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = '0;
      beats = 0;
      emit_row = -1;
      delay_left = 0;
    end else begin
      if (emit_row >= 0) begin
        if (delay_left > 0) begin
          delay_left--;
        end else begin
          arr_valid_out = 1'b1;
          for (int j = 0; j < N; j++) arr_c[j] = acc[emit_row][j];
          emit_row++;
          if (emit_row == stub_gap_after) delay_left = stub_gap;
          if (emit_row == N) emit_row = -1;
        end
      end
      if (arr_valid_in) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] = acc[i][j] + (32'(arr_a[i]) * 32'(arr_b[j]));
        beats++;
        if (beats == N && !stub_never) begin
          emit_row = 0;
          delay_left = stub_lat;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_row(input bit sel, input int r);
    logic [N*DW-1:0] d;
    d = '0;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(sel ? mb[r][j] : ma[r][j]);
    return d;
  endfunction

  function automatic logic [N*2*DW-1:0] exp_row(input int r);
    logic [N*2*DW-1:0] row;
    longint unsigned s;
    row = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(ma[r][k]) * longint'(mb[k][j]);
      row[j*2*DW +: 2*DW] = (2*DW)'(s);
    end
    return row;
  endfunction

  task automatic push(input bit sel, input int r);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_idx = IW'(r);
    wr_data = pack_row(sel, r);
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_ok", wr_err, 1'b0);
  endtask

  task automatic push_all();
    for (int r = 0; r < N; r++) begin
      push(1'b0, r);
      push(1'b1, r);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom_range(0, 65535);
        mb[i][j] = $urandom_range(0, 65535);
      end
    push_all();
  endtask

  task automatic run_job(input int stall_at, input int stall_len, input bit chk_lat,
                         input bit wr_with_start, input bit intrude);
    int cyc, got, stalled, first_v, wr_err_cnt;
    cyc = 0; got = 0; stalled = 0; first_v = -1; wr_err_cnt = 0;
    if (wr_with_start) begin
      for (int j = 0; j < N; j++) ma[N-1][j] = $urandom_range(0, 65535);
      wr_en = 1'b1;
      wr_sel = 1'b0;
      wr_idx = IW'(N - 1);
      wr_data = pack_row(1'b0, N - 1);
    end
    start = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);
    cyc = 1;
    start = 1'b0;
    wr_en = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_err_clr", err, 1'b0);
    while (got < N && cyc < 200) begin
      start = intrude && cyc == 2;
      wr_en = intrude && cyc == 2;
      if (wr_en) begin
        wr_sel = 1'b1;
        wr_idx = '0;
        wr_data = (N*DW)'({$urandom(), $urandom()});
      end
      if (wr_err) wr_err_cnt++;
      res_ready = !(got == stall_at && stalled < stall_len);
      if (res_valid && first_v < 0) first_v = cyc;
      if (res_valid) begin
        if (res_ready) begin
          check("row_idx", res_idx, got);
          check("row_data", res_row, exp_row(got));
          got++;
        end else begin
          check("hold_idx", res_idx, got);
          check("hold_row", res_row, exp_row(got));
          stalled++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    res_ready = 1'b0;
    check("rows_all", got, N);
    check("done_pulse", done, 1'b1);
    check("idle_after", busy, 1'b0);
    if (chk_lat) check("latency", first_v, 1 + 1 + N + stub_lat + N);
    if (intrude) check("wr_err_once", wr_err_cnt, 1);
    if (stall_len > 0) check("stall_len", stalled, stall_len);
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("still_idle", busy, 1'b0);
  endtask

  initial begin
    int cyc, rv_seen;
    rst_n = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
    start = 1'b0; res_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    check("rst_vin", arr_valid_in, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_arr_a", arr_a, '0);
    check("rst_res_idx", res_idx, '0);
    check("rst_arr_rst_n", arr_rst_n, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_arr_rst_n", arr_rst_n, 1'b1);

    // Identity times 1..9.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = N * i + j + 1;
      end
    push_all();
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);

    // All-2 times all-3 twice: stale accumulators would double the result.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 2;
        mb[i][j] = 3;
      end
    push_all();
    check("const_18", exp_row(1), {N{32'd18}});
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);

    // Random operands, array latency, 5-cycle downstream stall on row 1.
    stub_lat = 2;
    fill_rand();
    run_job(1, 5, 1'b1, 1'b0, 1'b0);

    // Gap in the array's result stream, with a row write landing alongside start.
    stub_lat = 1; stub_gap_after = 1; stub_gap = 3;
    fill_rand();
    run_job(-1, 0, 1'b0, 1'b1, 1'b0);
    stub_gap_after = 0; stub_gap = 0;
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);

    // start and wr_en while feeding are both ignored.
    run_job(-1, 0, 1'b1, 1'b0, 1'b1);

    // Array never answers: WAIT times out.
    stub_never = 1'b1;
    rv_seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (res_valid) rv_seen++;
      @(negedge clk);
      cyc++;
    end
    check("to_cycle", cyc, 1 + 1 + N + TO);
    check("to_err", err, 1'b1);
    check("to_no_res", rv_seen, 0);
    check("to_idle", busy, 1'b0);
    @(negedge clk);
    check("to_done_single", done, 1'b0);
    check("to_err_sticky", err, 1'b1);
    stub_never = 1'b0;
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);

    // Reset during FEED cycle 1.
    fill_rand();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_vin", arr_valid_in, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_vin", arr_valid_in, 1'b0);
    check("mid_arr_b", arr_b, '0);
    check("mid_arr_rst_n", arr_rst_n, 1'b0);
    check("mid_res_valid", res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_arr_rst_n", arr_rst_n, 1'b1);
    check("post_done", done, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);
    fill_rand();
    run_job(-1, 0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
